// File: rtl/gate_emulator_if.sv
// gate_emulator_if: tester-side bus of the 12-pin gate emulator.
// master = tester / gate finder side, slave = emulator.
interface gate_emulator_if #(
    parameter int DELAY_W = 4
);
    logic               enable;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [2:0]         cfg_type;
    logic [DELAY_W-1:0] cfg_delay;
    logic [11:0]        pins_in;
    logic [11:0]        tester_dir;
    logic [11:0]        pins_out;
    logic [11:0]        pins_dir;
    logic               contention;
    logic               cfg_err;
    logic [7:0]         eval_cnt;
    logic [11:0]        fault_mask;
    logic               fault_val;

    modport master (
        output enable, cfg_valid, cfg_type, cfg_delay, pins_in, tester_dir,
               fault_mask, fault_val,
        input  cfg_ready, pins_out, pins_dir, contention, cfg_err, eval_cnt
    );

    modport slave (
        input  enable, cfg_valid, cfg_type, cfg_delay, pins_in, tester_dir,
               fault_mask, fault_val,
        output cfg_ready, pins_out, pins_dir, contention, cfg_err, eval_cnt
    );
endinterface

// File: rtl/gate_emulator.sv
// gate_emulator: behavioural 12-pin logic-gate IC answering the gate finder.
// Decodes the configured gate type into pin directions, evaluates the gates
// with a programmable settle delay and flags pin contention.
// Optional build macro GATE_EMU_FAULT_EN: force emulator-driven pins in
// fault_mask to fault_val on top of the registered gate outputs.
module gate_emulator #(
    parameter int DELAY_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    gate_emulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, STABLE} state_t;

    localparam logic [2:0] T_NOT  = 3'd1;
    localparam logic [2:0] T_AND  = 3'd2;
    localparam logic [2:0] T_OR   = 3'd3;
    localparam logic [2:0] T_NAND = 3'd4;
    localparam logic [2:0] T_NOR  = 3'd5;
    localparam logic [2:0] T_XOR  = 3'd6;
    localparam logic [2:0] T_RSVD = 3'd7;

    // Pins the emulator drives for a given gate type.
    function automatic logic [11:0] out_mask(input logic [2:0] t);
        case (t)
            T_NOT:                              return 12'hAAA;
            T_AND, T_OR, T_NAND, T_NOR, T_XOR:  return 12'h924;
            default:                            return 12'h000;
        endcase
    endfunction

    // Gate outputs for the given pin levels; only output pins can be 1.
    function automatic logic [11:0] gate_eval(input logic [2:0] t, input logic [11:0] p);
        logic [11:0] r;
        logic        a, b;
        r = '0;
        if (t == T_NOT) begin
            for (int k = 0; k < 6; k++) r[2*k+1] = ~p[2*k];
        end else begin
            for (int k = 0; k < 4; k++) begin
                a = p[3*k];
                b = p[3*k+1];
                case (t)
                    T_AND:   r[3*k+2] = a & b;
                    T_OR:    r[3*k+2] = a | b;
                    T_NAND:  r[3*k+2] = ~(a & b);
                    T_NOR:   r[3*k+2] = ~(a | b);
                    T_XOR:   r[3*k+2] = a ^ b;
                    default: r[3*k+2] = 1'b0;
                endcase
            end
        end
        return r;
    endfunction

    state_t             st;
    logic [2:0]         typ_q;
    logic [DELAY_W-1:0] dly_q;
    logic [DELAY_W-1:0] cnt_q;
    logic [11:0]        in_q;
    logic [11:0]        out_q;
    logic [11:0]        dir_q;
    logic               ready_q;
    logic               con_q;
    logic               err_q;
    logic [7:0]         ev_q;

    logic               accept;
    logic               chg;
    logic [11:0]        f_val;
    logic [DELAY_W-1:0] rld;

    assign accept = bus.cfg_valid & ready_q;
    assign chg    = |((bus.pins_in ^ in_q) & ~out_mask(typ_q));
    assign f_val  = gate_eval(typ_q, bus.pins_in);
    // An input change is already one cycle old when seen against in_q, so
    // the reload is one short to keep the change-to-output latency at delay+1.
    assign rld    = (dly_q == '0) ? '0 : dly_q - 1'b1;

    // Sample tester pin levels every cycle for change detection.
    always_ff @(posedge clk) begin
        if (rst) in_q <= '0;
        else     in_q <= bus.pins_in;
    end

    // Sticky contention flag, cleared only by reset or a new configuration.
    always_ff @(posedge clk) begin
        if (rst)                              con_q <= 1'b0;
        else if (accept)                      con_q <= 1'b0;
        else if (|(bus.tester_dir & dir_q))   con_q <= 1'b1;
    end

    // Main FSM: configuration handshake, settle counter and gate evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            typ_q   <= '0;
            dly_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            dir_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            ev_q    <= '0;
        end else if (accept) begin
            // A new configuration wins over any simultaneous input change.
            typ_q <= bus.cfg_type;
            dly_q <= bus.cfg_delay;
            out_q <= '0;
            err_q <= (bus.cfg_type == T_RSVD);
            ev_q  <= '0;
            if (bus.enable) begin
                st      <= SETTLE;
                cnt_q   <= bus.cfg_delay;
                dir_q   <= out_mask(bus.cfg_type);
                ready_q <= 1'b0;
            end else begin
                st      <= IDLE;
                dir_q   <= '0;
                ready_q <= 1'b1;
            end
        end else if (!bus.enable) begin
            st      <= IDLE;
            out_q   <= '0;
            dir_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            case (st)
                IDLE: begin
                    st      <= SETTLE;
                    cnt_q   <= dly_q;
                    dir_q   <= out_mask(typ_q);
                    ready_q <= 1'b0;
                end
                SETTLE: begin
                    if (chg) begin
                        cnt_q <= rld;
                    end else if (cnt_q == '0) begin
                        out_q   <= f_val;
                        ev_q    <= (ev_q == 8'hFF) ? ev_q : ev_q + 8'd1;
                        st      <= STABLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STABLE: begin
                    if (chg) begin
                        if (dly_q == '0) begin
                            out_q <= f_val;
                            ev_q  <= (ev_q == 8'hFF) ? ev_q : ev_q + 8'd1;
                        end else begin
                            st      <= SETTLE;
                            cnt_q   <= rld;
                            ready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    st      <= IDLE;
                    out_q   <= '0;
                    dir_q   <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cfg_ready  = ready_q;
    assign bus.pins_dir   = dir_q;
    assign bus.contention = con_q;
    assign bus.cfg_err    = err_q;
    assign bus.eval_cnt   = ev_q;

`ifdef GATE_EMU_FAULT_EN
    // Forced level overrides only pins the emulator is actually driving.
    logic [11:0] force_m;
    assign force_m      = bus.fault_mask & dir_q;
    assign bus.pins_out = (out_q & ~force_m) | ({12{bus.fault_val}} & force_m);
`else
    logic unused_fault;
    assign unused_fault = ^{bus.fault_mask, bus.fault_val};
    assign bus.pins_out = out_q;
`endif
endmodule

// File: tb/tb_gate_emulator.sv
// tb_gate_emulator: table-driven directed vectors for gate_emulator plus
// hand-written fault-forcing and eval_cnt saturation sequences.
module tb_gate_emulator;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    gate_emulator_if #(.DELAY_W(4)) bus();
    gate_emulator #(.DELAY_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        r, en, cv;
        logic [2:0]  ct;
        logic [3:0]  cd;
        logic [11:0] pin, tdir;
        logic [11:0] e_out, e_dir;
        logic        e_con, e_err;
        logic [7:0]  e_ev;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[41];

    function automatic vec_t mk(input logic r, en, cv, input logic [2:0] ct, input logic [3:0] cd,
                                input logic [11:0] pin, tdir, eo, ed, input logic ec, ee,
                                input logic [7:0] ev, input logic er);
        vec_t v;
        v.r = r; v.en = en; v.cv = cv; v.ct = ct; v.cd = cd; v.pin = pin; v.tdir = tdir;
        v.e_out = eo; v.e_dir = ed; v.e_con = ec; v.e_err = ee; v.e_ev = ev; v.e_rdy = er;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [11:0] eo, ed, input logic ec, ee,
                           input logic [7:0] ev, input logic er);
        chk("pins_out",   idx, bus.pins_out, eo);
        chk("pins_dir",   idx, bus.pins_dir, ed);
        chk("contention", idx, {11'b0, bus.contention}, {11'b0, ec});
        chk("cfg_err",    idx, {11'b0, bus.cfg_err}, {11'b0, ee});
        chk("eval_cnt",   idx, {4'b0, bus.eval_cnt}, {4'b0, ev});
        chk("cfg_ready",  idx, {11'b0, bus.cfg_ready}, {11'b0, er});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] p;
        logic [11:0] fexp;

        rst = 1'b1;
        bus.enable = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_type = 3'd0; bus.cfg_delay = 4'd0;
        bus.pins_in = '0; bus.tester_dir = '0; bus.fault_mask = '0; bus.fault_val = 1'b0;

        // r en cv ct cd  pin      tdir    | out      dir      con err ev rdy
        tbl[0]  = mk(0,0,1,1,0, 12'h000,12'h000, 12'h000,12'h000,0,0,0,1); // accept NOT while disabled
        tbl[1]  = mk(0,1,0,0,0, 12'h000,12'h000, 12'h000,12'hAAA,0,0,0,0); // enable -> SETTLE
        tbl[2]  = mk(0,1,0,0,0, 12'h000,12'h000, 12'hAAA,12'hAAA,0,0,1,1);
        tbl[3]  = mk(0,1,0,0,0, 12'h001,12'h000, 12'hAA8,12'hAAA,0,0,2,1); // delay 0: 1 cycle
        tbl[4]  = mk(0,1,0,0,0, 12'h001,12'h000, 12'hAA8,12'hAAA,0,0,2,1);
        tbl[5]  = mk(0,1,0,0,0, 12'h003,12'h000, 12'hAA8,12'hAAA,0,0,2,1); // output pin change ignored
        tbl[6]  = mk(0,1,0,0,0, 12'h001,12'h002, 12'hAA8,12'hAAA,1,0,2,1); // contention
        tbl[7]  = mk(0,1,0,0,0, 12'h001,12'h000, 12'hAA8,12'hAAA,1,0,2,1); // sticky
        tbl[8]  = mk(0,1,0,0,0, 12'h015,12'h000, 12'hA80,12'hAAA,1,0,3,1);
        tbl[9]  = mk(0,1,1,1,0, 12'h015,12'h000, 12'h000,12'hAAA,0,0,0,0); // reconfig clears
        tbl[10] = mk(0,1,0,0,0, 12'h015,12'h000, 12'hA80,12'hAAA,0,0,1,1);
        tbl[11] = mk(0,1,1,4,3, 12'h000,12'h000, 12'h000,12'h924,0,0,0,0); // NAND delay 3
        tbl[12] = mk(0,1,0,0,0, 12'h000,12'h000, 12'h000,12'h924,0,0,0,0);
        tbl[13] = mk(0,1,0,0,0, 12'h000,12'h000, 12'h000,12'h924,0,0,0,0);
        tbl[14] = mk(0,1,0,0,0, 12'h000,12'h000, 12'h000,12'h924,0,0,0,0);
        tbl[15] = mk(0,1,0,0,0, 12'h000,12'h000, 12'h924,12'h924,0,0,1,1);
        tbl[16] = mk(0,1,0,0,0, 12'h003,12'h000, 12'h924,12'h924,0,0,1,0); // inputs 1,1
        tbl[17] = mk(0,1,0,0,0, 12'h003,12'h000, 12'h924,12'h924,0,0,1,0);
        tbl[18] = mk(0,1,0,0,0, 12'h003,12'h000, 12'h924,12'h924,0,0,1,0);
        tbl[19] = mk(0,1,0,0,0, 12'h003,12'h000, 12'h920,12'h924,0,0,2,1); // falls on cycle 4
        tbl[20] = mk(0,1,0,0,0, 12'h000,12'h000, 12'h920,12'h924,0,0,2,0);
        tbl[21] = mk(0,1,0,0,0, 12'h000,12'h000, 12'h920,12'h924,0,0,2,0);
        tbl[22] = mk(0,1,0,0,0, 12'h001,12'h000, 12'h920,12'h924,0,0,2,0); // toggle reloads
        tbl[23] = mk(0,1,0,0,0, 12'h001,12'h000, 12'h920,12'h924,0,0,2,0);
        tbl[24] = mk(0,1,0,0,0, 12'h001,12'h000, 12'h920,12'h924,0,0,2,0);
        tbl[25] = mk(0,1,0,0,0, 12'h001,12'h000, 12'h924,12'h924,0,0,3,1);
        tbl[26] = mk(0,1,0,0,0, 12'h003,12'h000, 12'h924,12'h924,0,0,3,0);
        tbl[27] = mk(0,1,1,7,0, 12'h003,12'h000, 12'h924,12'h924,0,0,3,0); // held off in SETTLE
        tbl[28] = mk(0,1,1,7,0, 12'h003,12'h000, 12'h924,12'h924,0,0,3,0);
        tbl[29] = mk(0,1,1,7,0, 12'h003,12'h000, 12'h920,12'h924,0,0,4,1);
        tbl[30] = mk(0,1,1,7,0, 12'h003,12'h000, 12'h000,12'h000,0,1,0,0); // reserved accepted
        tbl[31] = mk(0,1,0,0,0, 12'h003,12'h000, 12'h000,12'h000,0,1,1,1);
        tbl[32] = mk(0,1,1,6,2, 12'h001,12'h000, 12'h000,12'h924,0,0,0,0); // XOR delay 2
        tbl[33] = mk(0,0,0,0,0, 12'h001,12'h000, 12'h000,12'h000,0,0,0,1); // disable in SETTLE
        tbl[34] = mk(0,1,0,0,0, 12'h001,12'h000, 12'h000,12'h924,0,0,0,0); // re-enable
        tbl[35] = mk(0,1,0,0,0, 12'h001,12'h000, 12'h000,12'h924,0,0,0,0);
        tbl[36] = mk(0,1,0,0,0, 12'h001,12'h000, 12'h000,12'h924,0,0,0,0);
        tbl[37] = mk(0,1,0,0,0, 12'h001,12'h000, 12'h004,12'h924,0,0,1,1);
        tbl[38] = mk(0,1,0,0,0, 12'h003,12'h000, 12'h004,12'h924,0,0,1,0);
        tbl[39] = mk(1,1,0,0,0, 12'h003,12'h000, 12'h000,12'h000,0,0,0,1); // reset mid-SETTLE
        tbl[40] = mk(0,0,0,0,0, 12'h003,12'h000, 12'h000,12'h000,0,0,0,1);

        // Reset state
        tick();
        tick();
        chk_all(-1, 12'h000, 12'h000, 1'b0, 1'b0, 8'd0, 1'b1);

        for (int i = 0; i < 41; i++) begin
            rst = tbl[i].r; bus.enable = tbl[i].en; bus.cfg_valid = tbl[i].cv;
            bus.cfg_type = tbl[i].ct; bus.cfg_delay = tbl[i].cd;
            bus.pins_in = tbl[i].pin; bus.tester_dir = tbl[i].tdir;
            tick();
            chk_all(i, tbl[i].e_out, tbl[i].e_dir, tbl[i].e_con, tbl[i].e_err, tbl[i].e_ev, tbl[i].e_rdy);
        end

        // Fault forcing on XOR, inputs 1,1
        rst = 1'b0; bus.enable = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_type = 3'd6; bus.cfg_delay = 4'd0;
        bus.pins_in = 12'h003; bus.fault_mask = 12'h004; bus.fault_val = 1'b1;
`ifdef GATE_EMU_FAULT_EN
        fexp = 12'h004;
`else
        fexp = 12'h000;
`endif
        tick();
        chk_all(100, fexp, 12'h924, 1'b0, 1'b0, 8'd0, 1'b0);
        bus.cfg_valid = 1'b0;
        tick();
        chk_all(101, fexp, 12'h924, 1'b0, 1'b0, 8'd1, 1'b1);
        bus.fault_mask = 12'h005;          // input pin 0 in mask must stay untouched
        tick();
        chk("fault_in_pin", 102, bus.pins_out, fexp);
        bus.pins_in = 12'h001; bus.fault_mask = 12'h004; bus.fault_val = 1'b0;
        tick();
`ifdef GATE_EMU_FAULT_EN
        fexp = 12'h000;
`else
        fexp = 12'h004;
`endif
        chk("fault_low", 103, bus.pins_out, fexp);
        bus.fault_mask = 12'h000;
        #1;
        chk("fault_off", 104, bus.pins_out, 12'h004);

        // eval_cnt saturation with NOT, delay 0
        bus.cfg_valid = 1'b1; bus.cfg_type = 3'd1; bus.cfg_delay = 4'd0; bus.pins_in = 12'h000;
        tick();
        bus.cfg_valid = 1'b0;
        tick();
        chk("sat_start", 200, {4'b0, bus.eval_cnt}, 12'd1);
        for (int i = 0; i < 300; i++) begin
            p = '0;
            p[0] = ~i[0];
            bus.pins_in = p;
            tick();
            if (i == 252) chk("sat_254", i, {4'b0, bus.eval_cnt}, 12'd254);
            if (i == 253) chk("sat_255", i, {4'b0, bus.eval_cnt}, 12'd255);
        end
        chk("sat_end", 201, {4'b0, bus.eval_cnt}, 12'd255);
        chk("sat_out", 202, bus.pins_out, 12'hAAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
